// File: rtl/multi_field_bcd_display_if.sv
// Load/busy handshake bundle for multi_field_bcd_display: two binary fields in, status out.
interface multi_field_bcd_display_if #(
  parameter int unsigned BIN_W = 8
);
  logic             LOAD;
  logic [BIN_W-1:0] HI_IN;
  logic [BIN_W-1:0] LO_IN;
  logic             BUSY;
  logic             DONE;

  modport master (output LOAD, HI_IN, LO_IN, input BUSY, DONE);
  modport slave  (input LOAD, HI_IN, LO_IN, output BUSY, DONE);
endinterface

// File: rtl/multi_field_bcd_display.sv
// Two-field BCD seven-segment driver: sequential double-dabble conversion, multiplexed
// active-low anode scan with per-digit blink and optional leading-zero blanking.
module multi_field_bcd_display #(
  parameter int unsigned DIGITS_PER_FIELD = 2,
  parameter int unsigned BIN_W            = 8,
  parameter int unsigned REFRESH_DIV      = 1,
  parameter int unsigned BLINK_DIV        = 250,
  parameter bit          LZ_BLANK         = 1'b0
) (
  input  logic                            CLOCK,
  input  logic                            RESET,
  multi_field_bcd_display_if.slave        bus,
  input  logic [2*DIGITS_PER_FIELD-1:0]   BLINK_MASK,
  output logic [6:0]                      seg,
  output logic [2*DIGITS_PER_FIELD-1:0]   an
);
  localparam int unsigned D    = DIGITS_PER_FIELD;
  localparam int unsigned N    = 2 * D;
  localparam int unsigned BcdW = 4 * D;
  localparam int unsigned CntW = $clog2(BIN_W + 1);
  localparam int unsigned RefW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BlkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned IdxW = $clog2(N);
  localparam longint unsigned MaxVal = (64'd10 ** D) - 64'd1;

  function automatic logic [BIN_W-1:0] clamp(input logic [BIN_W-1:0] v);
    if (64'(v) > MaxVal) return BIN_W'(MaxVal);
    return v;
  endfunction

  // Add-3 correction applied to every nibble before each shift.
  function automatic logic [BcdW-1:0] adj(input logic [BcdW-1:0] b);
    logic [BcdW-1:0] r;
    r = b;
    for (int k = 0; k < int'(D); k++) begin
      if (r[4*k +: 4] >= 4'd5) r[4*k +: 4] = r[4*k +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] enc(input logic [3:0] d);
    unique case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  logic [BIN_W-1:0] hi_bin_q, hi_bin_d, lo_bin_q, lo_bin_d;
  logic [BcdW-1:0]  hi_bcd_q, hi_bcd_d, lo_bcd_q, lo_bcd_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [4*N-1:0]   digits_q, digits_d;
  logic [RefW-1:0]  ref_q, ref_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [BlkW-1:0]  blink_q, blink_d;
  logic             phase_q, phase_d;
  logic [N-1:0]     mask_q, mask_d;
  logic [N-1:0]     an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic [N-1:0]     lz;
  logic             tick, zero_run;

  // Conversion engine: digits_q only changes on the final iteration.
  always_comb begin
    hi_bin_d = hi_bin_q;
    lo_bin_d = lo_bin_q;
    hi_bcd_d = hi_bcd_q;
    lo_bcd_d = lo_bcd_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    digits_d = digits_q;
    if (busy_q) begin
      {hi_bcd_d, hi_bin_d} = {adj(hi_bcd_q), hi_bin_q} << 1;
      {lo_bcd_d, lo_bin_d} = {adj(lo_bcd_q), lo_bin_q} << 1;
      cnt_d = cnt_q - CntW'(1);
      if (cnt_q == CntW'(1)) begin
        busy_d   = 1'b0;
        done_d   = 1'b1;
        digits_d = {hi_bcd_d, lo_bcd_d};
      end
    end else if (bus.LOAD) begin
      hi_bin_d = clamp(bus.HI_IN);
      lo_bin_d = clamp(bus.LO_IN);
      hi_bcd_d = '0;
      lo_bcd_d = '0;
      cnt_d    = CntW'(BIN_W);
      busy_d   = 1'b1;
    end
  end

  // Scan timing: slot tick advances index, samples the blink mask and steps the blink timer.
  always_comb begin
    tick    = (ref_q == RefW'(REFRESH_DIV - 1));
    ref_d   = tick ? '0 : ref_q + RefW'(1);
    idx_d   = idx_q;
    blink_d = blink_q;
    phase_d = phase_q;
    mask_d  = mask_q;
    if (tick) begin
      idx_d  = (idx_q == IdxW'(N - 1)) ? '0 : idx_q + IdxW'(1);
      mask_d = BLINK_MASK;
      if (blink_q == BlkW'(BLINK_DIV - 1)) begin
        blink_d = '0;
        phase_d = ~phase_q;
      end else begin
        blink_d = blink_q + BlkW'(1);
      end
    end
  end

  // Leading zeros: walk each field from its top digit down, stopping above digit 0.
  always_comb begin
    lz       = '0;
    zero_run = 1'b1;
    for (int f = 0; f < 2; f++) begin
      zero_run = 1'b1;
      for (int j = int'(D) - 1; j >= 1; j--) begin
        zero_run = zero_run && (digits_q[4*(f*int'(D)+j) +: 4] == 4'd0);
        lz[f*int'(D)+j] = LZ_BLANK && zero_run;
      end
    end
  end

  always_comb begin
    an_d  = '1;
    seg_d = 7'b1111111;
    for (int i = 0; i < int'(N); i++) begin
      if (idx_q == IdxW'(i) && !(lz[i] || (mask_q[i] && !phase_q))) begin
        an_d[i] = 1'b0;
        seg_d   = enc(digits_q[4*i +: 4]);
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      hi_bin_q <= '0;
      lo_bin_q <= '0;
      hi_bcd_q <= '0;
      lo_bcd_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      digits_q <= '0;
      ref_q    <= '0;
      idx_q    <= '0;
      blink_q  <= '0;
      phase_q  <= 1'b1;
      mask_q   <= '0;
      an_q     <= '1;
      seg_q    <= 7'b1111111;
    end else begin
      hi_bin_q <= hi_bin_d;
      lo_bin_q <= lo_bin_d;
      hi_bcd_q <= hi_bcd_d;
      lo_bcd_q <= lo_bcd_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      digits_q <= digits_d;
      ref_q    <= ref_d;
      idx_q    <= idx_d;
      blink_q  <= blink_d;
      phase_q  <= phase_d;
      mask_q   <= mask_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
  assign an       = an_q;
  assign seg      = seg_q;
endmodule

// File: tb/tb_multi_field_bcd_display.sv
// Bench for multi_field_bcd_display: dut_a (BLINK_DIV=4) and dut_b (LZ_BLANK=1) against a
// decimal-arithmetic reference model.
module tb_multi_field_bcd_display;
  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] mask_a = '0, mask_b = '0;
  logic [6:0] seg_a, seg_b;
  logic [3:0] an_a, an_b;
  int passed = 0, total = 0;
  logic [3:0] cap_an [4];
  logic [6:0] cap_seg [4];

  multi_field_bcd_display_if #(.BIN_W(8)) bus_a ();
  multi_field_bcd_display_if #(.BIN_W(8)) bus_b ();

  multi_field_bcd_display #(
    .DIGITS_PER_FIELD(2), .BIN_W(8), .REFRESH_DIV(1), .BLINK_DIV(4), .LZ_BLANK(1'b0)
  ) dut_a (
    .CLOCK(CLOCK), .RESET(RESET), .bus(bus_a), .BLINK_MASK(mask_a), .seg(seg_a), .an(an_a)
  );

  multi_field_bcd_display #(
    .DIGITS_PER_FIELD(2), .BIN_W(8), .REFRESH_DIV(1), .BLINK_DIV(250), .LZ_BLANK(1'b1)
  ) dut_b (
    .CLOCK(CLOCK), .RESET(RESET), .bus(bus_b), .BLINK_MASK(mask_b), .seg(seg_b), .an(an_b)
  );

  always #5 CLOCK = ~CLOCK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Reference model: values saturate at 99, digits come from decimal division.
  function automatic int clampv(input int v);
    return (v > 99) ? 99 : v;
  endfunction

  function automatic int dig(input int hi, input int lo, input int k);
    case (k)
      0: return clampv(lo) % 10;
      1: return clampv(lo) / 10;
      2: return clampv(hi) % 10;
      default: return clampv(hi) / 10;
    endcase
  endfunction

  function automatic bit lz_exp(input int hi, input int lo, input int k);
    if (k == 1) return clampv(lo) < 10;
    if (k == 3) return clampv(hi) < 10;
    return 1'b0;
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  function automatic logic rd_busy(input int sel);
    return (sel != 0) ? bus_b.BUSY : bus_a.BUSY;
  endfunction
  function automatic logic rd_done(input int sel);
    return (sel != 0) ? bus_b.DONE : bus_a.DONE;
  endfunction
  function automatic logic [3:0] rd_an(input int sel);
    return (sel != 0) ? an_b : an_a;
  endfunction
  function automatic logic [6:0] rd_seg(input int sel);
    return (sel != 0) ? seg_b : seg_a;
  endfunction

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic set_in(input int sel, input logic ld, input int hi, input int lo);
    if (sel != 0) begin
      bus_b.LOAD = ld; bus_b.HI_IN = 8'(hi); bus_b.LO_IN = 8'(lo);
    end else begin
      bus_a.LOAD = ld; bus_a.HI_IN = 8'(hi); bus_a.LO_IN = 8'(lo);
    end
  endtask

  // Single LOAD pulse, then counts BUSY and DONE samples over a bounded window.
  task automatic do_load(input int sel, input int hi, input int lo,
                         output int busy_n, output int done_n);
    step();
    set_in(sel, 1'b1, hi, lo);
    step();
    set_in(sel, 1'b0, hi, lo);
    busy_n = 0;
    done_n = 0;
    for (int c = 0; c < 20; c++) begin
      if (rd_busy(sel) === 1'b1) busy_n++;
      if (rd_done(sel) === 1'b1) done_n++;
      step();
    end
  endtask

  // Aligns on digit 0 (never blanked) and records four consecutive scan slots.
  task automatic capture(input int sel, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (rd_an(sel) !== 4'b1110 && n < 40) begin
      step();
      n++;
    end
    if (rd_an(sel) === 4'b1110) begin
      ok = 1'b1;
      for (int k = 0; k < 4; k++) begin
        cap_an[k]  = rd_an(sel);
        cap_seg[k] = rd_seg(sel);
        if (k < 3) step();
      end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) step();
    for (int s = 0; s < 2; s++) begin
      total++; if (rd_an(s) !== 4'b1111) $display("FAIL reset_an[%0d]: got %b expected 1111", s, rd_an(s)); else passed++;
      total++; if (rd_seg(s) !== 7'b1111111) $display("FAIL reset_seg[%0d]: got %b expected 1111111", s, rd_seg(s)); else passed++;
      total++; if (rd_busy(s) !== 1'b0) $display("FAIL reset_busy[%0d]: got %b expected 0", s, rd_busy(s)); else passed++;
      total++; if (rd_done(s) !== 1'b0) $display("FAIL reset_done[%0d]: got %b expected 0", s, rd_done(s)); else passed++;
    end
    RESET = 1'b0;
    step();
  endtask

  // Load (hi, lo) into dut_a and verify handshake timing and the full scan.
  task automatic test_value(input string name, input int hi, input int lo);
    int bn, dn;
    bit ok;
    logic [3:0] exp_an;
    do_load(0, hi, lo, bn, dn);
    total++; if (bn !== 8) $display("FAIL %s_busy_len: got %0d expected 8", name, bn); else passed++;
    total++; if (dn !== 1) $display("FAIL %s_done_cnt: got %0d expected 1", name, dn); else passed++;
    capture(0, ok);
    total++; if (ok !== 1'b1) $display("FAIL %s_scan_align: got %b expected 1", name, ok); else passed++;
    for (int k = 0; k < 4; k++) begin
      exp_an = ~(4'b0001 << k);
      total++; if (cap_an[k] !== exp_an) $display("FAIL %s_an[%0d]: got %b expected %b", name, k, cap_an[k], exp_an); else passed++;
      total++; if (cap_seg[k] !== seg_of(dig(hi, lo, k))) $display("FAIL %s_seg[%0d]: got %b expected %b", name, k, cap_seg[k], seg_of(dig(hi, lo, k))); else passed++;
    end
  endtask

  task automatic test_basic();
    test_value("basic", 42, 7);
  endtask

  task automatic test_overflow();
    test_value("overflow", 255, 100);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) test_value("random", int'($urandom_range(255)), int'($urandom_range(255)));
  endtask

  task automatic test_handshake();
    int bn, dn;
    bit ok;
    step();
    set_in(0, 1'b1, 33, 66);
    step();
    set_in(0, 1'b0, 33, 66);
    bn = 0;
    dn = 0;
    for (int c = 0; c < 24; c++) begin
      if (c == 3) set_in(0, 1'b1, 11, 11);
      if (c == 4) set_in(0, 1'b0, 11, 11);
      if (bus_a.BUSY === 1'b1) bn++;
      if (bus_a.DONE === 1'b1) dn++;
      step();
    end
    total++; if (bn !== 8) $display("FAIL hs_busy_len: got %0d expected 8", bn); else passed++;
    total++; if (dn !== 1) $display("FAIL hs_done_cnt: got %0d expected 1", dn); else passed++;
    capture(0, ok);
    total++; if (ok !== 1'b1) $display("FAIL hs_scan_align: got %b expected 1", ok); else passed++;
    for (int k = 0; k < 4; k++) begin
      total++; if (cap_seg[k] !== seg_of(dig(33, 66, k))) $display("FAIL hs_seg[%0d]: got %b expected %b", k, cap_seg[k], seg_of(dig(33, 66, k))); else passed++;
    end
  endtask

  // LOAD held high: ignored on the cycle BUSY falls, accepted on the next.
  task automatic test_back_to_back();
    int n, bn, dn;
    bit ok;
    step();
    set_in(0, 1'b1, 12, 34);
    step();
    set_in(0, 1'b1, 56, 78);
    n = 0;
    while (bus_a.BUSY === 1'b1 && n < 20) begin
      n++;
      step();
    end
    total++; if (n !== 8) $display("FAIL b2b_first_busy: got %0d expected 8", n); else passed++;
    total++; if (bus_a.DONE !== 1'b1) $display("FAIL b2b_done_at_fall: got %b expected 1", bus_a.DONE); else passed++;
    step();
    total++; if (bus_a.BUSY !== 1'b1) $display("FAIL b2b_reaccept: got %b expected 1", bus_a.BUSY); else passed++;
    total++; if (bus_a.DONE !== 1'b0) $display("FAIL b2b_done_width: got %b expected 0", bus_a.DONE); else passed++;
    set_in(0, 1'b0, 56, 78);
    bn = 0;
    dn = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus_a.BUSY === 1'b1) bn++;
      if (bus_a.DONE === 1'b1) dn++;
      step();
    end
    total++; if (bn !== 8) $display("FAIL b2b_second_busy: got %0d expected 8", bn); else passed++;
    total++; if (dn !== 1) $display("FAIL b2b_second_done: got %0d expected 1", dn); else passed++;
    capture(0, ok);
    total++; if (ok !== 1'b1) $display("FAIL b2b_scan_align: got %b expected 1", ok); else passed++;
    for (int k = 0; k < 4; k++) begin
      total++; if (cap_seg[k] !== seg_of(dig(56, 78, k))) $display("FAIL b2b_seg[%0d]: got %b expected %b", k, cap_seg[k], seg_of(dig(56, 78, k))); else passed++;
    end
  endtask

  task automatic test_blink();
    int bn, dn, n, blanks, idx;
    bit blank [64];
    logic [3:0] exp_an;
    do_load(0, 42, 7, bn, dn);
    mask_a = 4'b1100;
    repeat (4) step();
    n = 0;
    while (an_a !== 4'b1110 && n < 40) begin
      step();
      n++;
    end
    total++; if (an_a !== 4'b1110) $display("FAIL blink_align: got %b expected 1110", an_a); else passed++;
    blanks = 0;
    for (int k = 0; k < 64; k++) begin
      idx      = k % 4;
      exp_an   = ~(4'b0001 << idx);
      blank[k] = 1'b0;
      if (idx < 2 || an_a !== 4'b1111) begin
        total++; if (an_a !== exp_an) $display("FAIL blink_an[%0d]: got %b expected %b", k, an_a, exp_an); else passed++;
        total++; if (seg_a !== seg_of(dig(42, 7, idx))) $display("FAIL blink_seg[%0d]: got %b expected %b", k, seg_a, seg_of(dig(42, 7, idx))); else passed++;
      end else begin
        blank[k] = 1'b1;
        blanks++;
      end
      step();
    end
    total++; if (blanks !== 16) $display("FAIL blink_blank_count: got %0d expected 16", blanks); else passed++;
    for (int k = 0; k < 56; k++) begin
      if (k % 4 >= 2) begin
        total++; if (blank[k] !== blank[k+8]) $display("FAIL blink_period[%0d]: got %b expected %b", k, blank[k+8], blank[k]); else passed++;
        total++; if (blank[k] === blank[k+4]) $display("FAIL blink_halfperiod[%0d]: got %b expected %b", k, blank[k+4], ~blank[k]); else passed++;
      end
    end
    mask_a = 4'b0000;
    repeat (4) step();
  endtask

  task automatic test_lz();
    int bn, dn, hi, lo;
    bit ok;
    logic [3:0] exp_an;
    for (int r = 0; r < 5; r++) begin
      hi = (r == 0) ? 5 : int'($urandom_range(120));
      lo = (r == 0) ? 0 : int'($urandom_range(15));
      do_load(1, hi, lo, bn, dn);
      total++; if (bn !== 8) $display("FAIL lz_busy_len: got %0d expected 8", bn); else passed++;
      total++; if (dn !== 1) $display("FAIL lz_done_cnt: got %0d expected 1", dn); else passed++;
      capture(1, ok);
      total++; if (ok !== 1'b1) $display("FAIL lz_scan_align: got %b expected 1", ok); else passed++;
      for (int k = 0; k < 4; k++) begin
        exp_an = lz_exp(hi, lo, k) ? 4'b1111 : ~(4'b0001 << k);
        total++; if (cap_an[k] !== exp_an) $display("FAIL lz_an[%0d] hi=%0d lo=%0d: got %b expected %b", k, hi, lo, cap_an[k], exp_an); else passed++;
        if (!lz_exp(hi, lo, k)) begin
          total++; if (cap_seg[k] !== seg_of(dig(hi, lo, k))) $display("FAIL lz_seg[%0d] hi=%0d lo=%0d: got %b expected %b", k, hi, lo, cap_seg[k], seg_of(dig(hi, lo, k))); else passed++;
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int bn, dn;
    bit ok;
    step();
    set_in(0, 1'b1, 42, 7);
    step();
    set_in(0, 1'b0, 42, 7);
    repeat (3) step();
    RESET = 1'b1;
    step();
    total++; if (bus_a.BUSY !== 1'b0) $display("FAIL rmid_busy: got %b expected 0", bus_a.BUSY); else passed++;
    total++; if (bus_a.DONE !== 1'b0) $display("FAIL rmid_done: got %b expected 0", bus_a.DONE); else passed++;
    total++; if (an_a !== 4'b1111) $display("FAIL rmid_an: got %b expected 1111", an_a); else passed++;
    RESET = 1'b0;
    bn = 0;
    dn = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus_a.BUSY === 1'b1) bn++;
      if (bus_a.DONE === 1'b1) dn++;
      step();
    end
    total++; if (bn !== 0) $display("FAIL rmid_busy_after: got %0d expected 0", bn); else passed++;
    total++; if (dn !== 0) $display("FAIL rmid_done_after: got %0d expected 0", dn); else passed++;
    capture(0, ok);
    total++; if (ok !== 1'b1) $display("FAIL rmid_scan_align: got %b expected 1", ok); else passed++;
    for (int k = 0; k < 4; k++) begin
      total++; if (cap_seg[k] !== 7'b1000000) $display("FAIL rmid_seg[%0d]: got %b expected 1000000", k, cap_seg[k]); else passed++;
    end
  endtask

  initial begin
    set_in(0, 1'b0, 0, 0);
    set_in(1, 1'b0, 0, 0);
    test_reset();
    test_basic();
    test_overflow();
    test_random();
    test_handshake();
    test_back_to_back();
    test_blink();
    test_lz();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
